// File: rtl/pulseox_pkg.sv
// Shared types and constants for the pulse-oximeter LED/ADC front end.
package pulseox_pkg;

  localparam int ADC_W = 8;

  localparam logic PH_IR  = 1'b0;
  localparam logic PH_RED = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    SETTLE,
    START,
    WAIT,
    HOLD
  } seq_state_t;

  // The phase LED is lit from the end of the dead time until the phase wraps.
  function automatic logic led_phase_on(input seq_state_t s);
    return (s == SETTLE) || (s == START) || (s == WAIT) || (s == HOLD);
  endfunction

endpackage

// File: rtl/led_adc_sequencer_phase_timer.sv
// Wrapping per-phase cycle counter; toggles the IR/red phase on every wrap.
module phase_timer
  import pulseox_pkg::*;
#(
  parameter int PHASE_CYC = 5000,
  parameter int CNT_W     = $clog2(PHASE_CYC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             phase,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYC - 1);

  assign wrap = !clear && (count == LAST);

  // A cleared timer always restarts in the IR phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_IR;
    end else if (clear) begin
      count <= '0;
      phase <= PH_IR;
    end else if (wrap) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_adc_sequencer.sv
// Alternating IR/red LED drive with one ADC conversion per phase, per-channel
// sample capture and the downstream filter sample clock.
module led_adc_sequencer
  import pulseox_pkg::*;
#(
  parameter int PHASE_CYC  = 5000,
  parameter int DEAD_CYC   = 2,
  parameter int SETTLE_CYC = 1000,
  parameter int TMO_CYC    = 200
) (
  input  logic             CLK_Sys,
  input  logic             rst_n,
  input  logic             En,
  input  logic             Err_Clr,
  input  logic             ADC_Done,
  input  logic [ADC_W-1:0] ADC_Data,
  output logic             ADC_Start,
  output logic             LED_IR,
  output logic             LED_RED,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic             IR_Valid,
  output logic             RED_Valid,
  output logic             CLK_Filter,
  output logic             Err_Timeout
);

  localparam int CNT_W = $clog2(PHASE_CYC);

  localparam logic [CNT_W-1:0] DEAD_END   = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(DEAD_CYC + SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_AT     = CNT_W'(DEAD_CYC + SETTLE_CYC + TMO_CYC);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic             phase;
  logic             wrap;
  logic             capture;
  logic             timeout;
  logic             ir_done;

  phase_timer #(
    .PHASE_CYC(PHASE_CYC),
    .CNT_W    (CNT_W)
  ) u_phase_timer (
    .clk  (CLK_Sys),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .count(count),
    .phase(phase),
    .wrap (wrap)
  );

  always_ff @(posedge CLK_Sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The phase counter owns the timing: a wrap forces DEAD even if the ADC stalls.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    timeout    = 1'b0;
    if (!En) begin
      state_next = IDLE;
    end else if (wrap) begin
      state_next = DEAD;
    end else begin
      case (state)
        IDLE:   state_next = DEAD;
        DEAD:   if (count == DEAD_END) state_next = SETTLE;
        SETTLE: if (count == SETTLE_END) state_next = START;
        START:  state_next = WAIT;
        WAIT: begin
          if (ADC_Done) begin
            capture    = 1'b1;
            state_next = HOLD;
          end else if (count == TMO_AT) begin
            timeout    = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD:    state_next = HOLD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_Sys or negedge rst_n) begin
    if (!rst_n) begin
      LED_IR        <= 1'b0;
      LED_RED       <= 1'b0;
      ADC_Start     <= 1'b0;
      IR_Valid      <= 1'b0;
      RED_Valid     <= 1'b0;
      IR_ADC_Value  <= '0;
      RED_ADC_Value <= '0;
      ir_done       <= 1'b0;
      Err_Timeout   <= 1'b0;
      CLK_Filter    <= 1'b0;
    end else begin
      LED_IR    <= led_phase_on(state_next) && (phase == PH_IR);
      LED_RED   <= led_phase_on(state_next) && (phase == PH_RED);
      ADC_Start <= (state_next == START);
      IR_Valid  <= capture && (phase == PH_IR);
      RED_Valid <= capture && (phase == PH_RED);
      if (capture && (phase == PH_IR))  IR_ADC_Value  <= ADC_Data;
      if (capture && (phase == PH_RED)) RED_ADC_Value <= ADC_Data;
      // A timed-out IR conversion still ends the IR wait, keeping the filter cadence.
      ir_done <= (capture || timeout) && (phase == PH_IR);
      if (timeout)      Err_Timeout <= 1'b1;
      else if (Err_Clr) Err_Timeout <= 1'b0;
      if ((state_next == IDLE) || (wrap && (phase == PH_IR))) CLK_Filter <= 1'b0;
      else if (ir_done)                                      CLK_Filter <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed-plus-random bench for led_adc_sequencer against a timeline model of the phases.
module tb_led_adc_sequencer;

  localparam int PHASE  = 500;
  localparam int DEAD   = 2;
  localparam int SETTLE = 100;
  localparam int TMO    = 20;

  localparam int MODE_FIXED    = 0;
  localparam int MODE_RED_MUTE = 1;
  localparam int MODE_RANDOM   = 2;

  logic       CLK_Sys;
  logic       rst_n;
  logic       En;
  logic       Err_Clr;
  logic       ADC_Done;
  logic [7:0] ADC_Data;
  logic       ADC_Start;
  logic       LED_IR;
  logic       LED_RED;
  logic [7:0] IR_ADC_Value;
  logic [7:0] RED_ADC_Value;
  logic       IR_Valid;
  logic       RED_Valid;
  logic       CLK_Filter;
  logic       Err_Timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Timeline model: m_t counts cycles since the sequencer left idle.
  bit         m_run;
  int         m_t;
  bit         m_wait;
  int         m_ts;
  bit         m_arm;
  logic [7:0] m_ir_val;
  logic [7:0] m_red_val;
  bit         m_ir_vld;
  bit         m_red_vld;
  bit         m_err;
  bit         m_clk;

  int         adc_mode = MODE_FIXED;
  int         done_cnt = 0;
  logic [7:0] done_data = 8'h00;
  bit         clr_req = 1'b0;
  bit         spur_req = 1'b0;
  int         rise_last = 0;
  int         rise_prev = 0;
  logic       prev_clk = 1'b0;

  led_adc_sequencer #(
    .PHASE_CYC (PHASE),
    .DEAD_CYC  (DEAD),
    .SETTLE_CYC(SETTLE),
    .TMO_CYC   (TMO)
  ) dut (
    .CLK_Sys      (CLK_Sys),
    .rst_n        (rst_n),
    .En           (En),
    .Err_Clr      (Err_Clr),
    .ADC_Done     (ADC_Done),
    .ADC_Data     (ADC_Data),
    .ADC_Start    (ADC_Start),
    .LED_IR       (LED_IR),
    .LED_RED      (LED_RED),
    .IR_ADC_Value (IR_ADC_Value),
    .RED_ADC_Value(RED_ADC_Value),
    .IR_Valid     (IR_Valid),
    .RED_Valid    (RED_Valid),
    .CLK_Filter   (CLK_Filter),
    .Err_Timeout  (Err_Timeout)
  );

  initial CLK_Sys = 1'b0;
  always #5 CLK_Sys = ~CLK_Sys;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the sequence completed");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int ph_of(input int t);
    return (t / PHASE) % 2;
  endfunction

  function automatic int pos_of(input int t);
    return t % PHASE;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_t = 0; m_wait = 0; m_ts = 0; m_arm = 0;
    m_ir_val = 8'h00; m_red_val = 8'h00;
    m_ir_vld = 0; m_red_vld = 0; m_err = 0; m_clk = 0;
  endfunction

  function automatic void model_edge(input logic rst, input logic en, input logic done,
                                     input logic [7:0] data, input logic clr);
    bit cap, tmo, clk_n;
    if (!rst) begin
      model_reset();
      return;
    end
    cap   = m_run && en && m_wait && done;
    tmo   = m_run && en && m_wait && !done && (m_t == m_ts + TMO);
    clk_n = m_clk;
    if (m_arm && m_run && en) clk_n = 1;
    if (m_run && en && pos_of(m_t + 1) == 0 && ph_of(m_t + 1) == 1) clk_n = 0;
    if (!en) clk_n = 0;
    m_ir_vld  = cap && ph_of(m_t) == 0;
    m_red_vld = cap && ph_of(m_t) == 1;
    if (m_ir_vld)  m_ir_val  = data;
    if (m_red_vld) m_red_val = data;
    m_arm = (cap || tmo) && ph_of(m_t) == 0;
    if (tmo)      m_err = 1;
    else if (clr) m_err = 0;
    m_clk = clk_n;
    if (cap || tmo) m_wait = 0;
    if (!en) begin
      m_run  = 0;
      m_wait = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
    end else begin
      m_t++;
    end
    if (m_run && pos_of(m_t) == DEAD + SETTLE + 1) begin
      m_wait = 1;
      m_ts   = m_t - 1;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      ADC_Done = 1'b0;
      ADC_Data = 8'($urandom);
      Err_Clr  = clr_req;
      clr_req  = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          ADC_Done = 1'b1;
          ADC_Data = done_data;
        end
      end
      if (spur_req) begin
        ADC_Done = 1'b1;
        ADC_Data = 8'hFF;
        spur_req = 1'b0;
      end
      if (adc_mode == MODE_RANDOM) begin
        if ($urandom_range(0, 63) == 0) ADC_Done = 1'b1;
        if ($urandom_range(0, 99) == 0) Err_Clr = 1'b1;
      end
      @(posedge CLK_Sys);
      model_edge(rst_n, En, ADC_Done, ADC_Data, Err_Clr);
      cyc++;
      #1;
      checkOutput("led_ir", LED_IR, m_run && ph_of(m_t) == 0 && pos_of(m_t) >= DEAD);
      checkOutput("led_red", LED_RED, m_run && ph_of(m_t) == 1 && pos_of(m_t) >= DEAD);
      checkOutput("led_overlap", LED_IR & LED_RED, 0);
      checkOutput("adc_start", ADC_Start, m_run && pos_of(m_t) == DEAD + SETTLE);
      checkOutput("ir_valid", IR_Valid, m_ir_vld);
      checkOutput("red_valid", RED_Valid, m_red_vld);
      checkOutput("ir_value", IR_ADC_Value, m_ir_val);
      checkOutput("red_value", RED_ADC_Value, m_red_val);
      checkOutput("clk_filter", CLK_Filter, m_clk);
      checkOutput("err_timeout", Err_Timeout, m_err);
      if (CLK_Filter === 1'b1 && prev_clk === 1'b0) begin
        rise_prev = rise_last;
        rise_last = cyc;
      end
      prev_clk = CLK_Filter;
      // ADC behaviour: answer each start request according to the current mode.
      if (ADC_Start === 1'b1) begin
        if (adc_mode == MODE_RANDOM) begin
          done_cnt  = $urandom_range(1, TMO + 3);
          done_data = 8'($urandom);
        end else if (adc_mode == MODE_RED_MUTE && ph_of(m_t) == 1) begin
          done_cnt = 0;
        end else begin
          done_cnt  = 10;
          done_data = (ph_of(m_t) == 0) ? 8'h5A : 8'hA5;
        end
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; En = 1'b0; Err_Clr = 1'b0; ADC_Done = 1'b0; ADC_Data = 8'h00;
    model_reset();
    $display("[TB] reset");
    applyStimulus(3);
    rst_n = 1'b1;
    applyStimulus(2);

    $display("[TB] nominal IR/red sequence");
    En = 1'b1;
    applyStimulus(2 * PHASE + 200);
    checkOutput("clk_filter_period", rise_last - rise_prev, 2 * PHASE);
    checkOutput("nominal_ir_value", IR_ADC_Value, 8'h5A);
    checkOutput("nominal_red_value", RED_ADC_Value, 8'hA5);

    $display("[TB] red conversion never answered");
    adc_mode = MODE_RED_MUTE;
    n = 0;
    while (!(m_run && ph_of(m_t) == 1 && pos_of(m_t) == DEAD + SETTLE + TMO) && n < 2 * PHASE) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("reach_red_timeout", n < 2 * PHASE, 1);
    checkOutput("err_before_timeout", Err_Timeout, 0);
    applyStimulus(1);
    checkOutput("err_after_timeout", Err_Timeout, 1);
    checkOutput("red_value_kept", RED_ADC_Value, 8'hA5);
    checkOutput("red_valid_absent", RED_Valid, 0);
    n = 0;
    while (!(m_run && ph_of(m_t) == 0 && pos_of(m_t) == DEAD) && n < 2 * PHASE) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("reach_next_ir", n < 2 * PHASE, 1);
    checkOutput("ir_on_time_after_timeout", LED_IR, 1);

    $display("[TB] error flag clear behaviour");
    clr_req = 1'b1;
    applyStimulus(1);
    checkOutput("err_clear_alone", Err_Timeout, 0);
    n = 0;
    while (!(m_wait && ph_of(m_t) == 1 && m_t == m_ts + TMO) && n < 2 * PHASE) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("reach_second_timeout", n < 2 * PHASE, 1);
    clr_req = 1'b1;
    applyStimulus(1);
    checkOutput("err_set_beats_clear", Err_Timeout, 1);

    $display("[TB] spurious done during settle");
    adc_mode = MODE_FIXED;
    n = 0;
    while (!(m_run && ph_of(m_t) == 0 && pos_of(m_t) == DEAD + 10) && n < 2 * PHASE) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("reach_ir_settle", n < 2 * PHASE, 1);
    spur_req = 1'b1;
    applyStimulus(1);
    checkOutput("spur_ir_valid", IR_Valid, 0);
    checkOutput("spur_red_valid", RED_Valid, 0);
    checkOutput("spur_ir_value", IR_ADC_Value, 8'h5A);
    checkOutput("spur_red_value", RED_ADC_Value, 8'hA5);

    $display("[TB] enable dropped during wait");
    n = 0;
    while (!(m_wait && m_t == m_ts + 3) && n < 2 * PHASE) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("reach_wait", n < 2 * PHASE, 1);
    done_data = 8'h3C;
    En = 1'b0;
    applyStimulus(1);
    checkOutput("abort_led_ir", LED_IR, 0);
    checkOutput("abort_led_red", LED_RED, 0);
    checkOutput("abort_start", ADC_Start, 0);
    checkOutput("abort_clk_filter", CLK_Filter, 0);
    applyStimulus(12);
    checkOutput("abort_ir_value", IR_ADC_Value, 8'h5A);
    checkOutput("abort_red_value", RED_ADC_Value, 8'hA5);
    En = 1'b1;
    applyStimulus(DEAD);
    checkOutput("restart_dead", LED_IR, 0);
    applyStimulus(1);
    checkOutput("restart_ir_on", LED_IR, 1);

    $display("[TB] random ADC latency and data");
    adc_mode = MODE_RANDOM;
    applyStimulus(12 * PHASE);

    $display("[TB] reset during hold");
    adc_mode = MODE_FIXED;
    n = 0;
    while (!(m_run && ph_of(m_t) == 0 && pos_of(m_t) == DEAD + SETTLE + TMO + 30) && n < 2 * PHASE + 10) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("reach_ir_hold", n < 2 * PHASE + 10, 1);
    checkOutput("hold_led_ir", LED_IR, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_led_ir", LED_IR, 0);
    checkOutput("async_led_red", LED_RED, 0);
    checkOutput("async_start", ADC_Start, 0);
    checkOutput("async_ir_value", IR_ADC_Value, 0);
    checkOutput("async_red_value", RED_ADC_Value, 0);
    checkOutput("async_ir_valid", IR_Valid, 0);
    checkOutput("async_red_valid", RED_Valid, 0);
    checkOutput("async_clk_filter", CLK_Filter, 0);
    checkOutput("async_err", Err_Timeout, 0);
    model_reset();
    done_cnt = 0;
    applyStimulus(2);
    rst_n = 1'b1;
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (LED_IR !== 1'b1 && n < 50);
    checkOutput("post_reset_ir_rise", n, DEAD + 1);
    applyStimulus(2 * PHASE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
